// File: rtl/bonsai_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bonsai_writer_pkg
// Purpose : Shared definitions for the output line writer. Holds the writer
//           FSM state encoding, the line size in bytes, and the elaboration
//           check on line/beat geometry.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
package bonsai_writer_pkg;

  // Writer FSM encoding. The width is fixed so the encoding stays stable
  // across tools and builds.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } writer_state_e;

  localparam int DEFAULT_LINE_WIDTH = 512;

  // Bytes per memory line for a given line width in bits.
  function automatic int line_bytes(input int line_width);
    return line_width / 8;
  endfunction

  // Line size of the default 512-bit configuration.
  localparam int LINE_BYTES = DEFAULT_LINE_WIDTH / 8;

  // A line must hold a whole, power-of-two number of beats and a whole
  // number of bytes.
  function automatic bit line_geometry_ok(input int line_width, input int beat_width);
    int ratio;
    if (beat_width <= 0 || line_width <= 0) return 1'b0;
    if ((line_width % beat_width) != 0) return 1'b0;
    if ((line_width % 8) != 0) return 1'b0;
    ratio = line_width / beat_width;
    return (ratio >= 1) && ((ratio & (ratio - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/output_line_writer_line_packer.sv
`default_nettype none
// ============================================================================
// Module  : line_packer
// Purpose : Slot counter and line accumulator. Beats are written into
//           consecutive slots of a line, slot 0 in the LSBs. Two views of
//           the line are offered combinationally:
//             merged_line - accumulator with the incoming beat already
//                           placed in the current slot
//             padded_line - filled slots kept, unfilled slots all-ones
// Ports   : clk, rst        clock / async active-high reset
//           clear           restart at slot 0
//           push, beat      store beat in current slot and advance
//           slot            current fill position
//           merged_line     line including the beat being pushed
//           padded_line     partial line padded with max-key sentinels
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
module line_packer #(
  parameter int BEAT_W = 128,
  parameter int R      = 4,
  parameter int SLOT_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                push,
  input  logic [BEAT_W-1:0]   beat,
  output logic [SLOT_W-1:0]   slot,
  output logic [R*BEAT_W-1:0] merged_line,
  output logic [R*BEAT_W-1:0] padded_line
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(R - 1);

  logic [R*BEAT_W-1:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
      acc  <= '0;
    end else if (clear) begin
      // Stale accumulator contents are harmless: only slots below the
      // current slot are ever read back.
      slot <= '0;
    end else if (push) begin
      for (int k = 0; k < R; k++) begin
        if (slot == SLOT_W'(k)) acc[k*BEAT_W +: BEAT_W] <= beat;
      end
      slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
    end
  end

  for (genvar k = 0; k < R; k++) begin : g_slot
    assign merged_line[k*BEAT_W +: BEAT_W] =
      (push && (slot == SLOT_W'(k))) ? beat : acc[k*BEAT_W +: BEAT_W];
    assign padded_line[k*BEAT_W +: BEAT_W] =
      (SLOT_W'(k) < slot) ? acc[k*BEAT_W +: BEAT_W] : {BEAT_W{1'b1}};
  end

endmodule
`default_nettype wire

// File: rtl/output_line_writer.sv
`default_nettype none
// ============================================================================
// Module  : output_line_writer
// Purpose : Packs beats from a first-word-fall-through FIFO into memory
//           lines and issues them as a valid/ready write stream at
//           consecutive line addresses. A job writes i_num_lines lines from
//           i_base_addr; i_flush ends the stream early, padding a partial
//           line with all-ones sentinels.
// Ports   : i_clk, i_rst               clock / async active-high reset
//           i_start, i_base_addr,
//           i_num_lines                job start and parameters
//           i_data, i_fifo_empty,
//           o_fifo_read                FIFO head and pop
//           i_flush                    end of stream
//           o_wr_valid, o_wr_addr,
//           o_wr_data, i_wr_ready      line write channel
//           o_busy, o_done             job status
//           o_stall_cycles             write backpressure cycles (optional)
// Config  : WRITER_PERF_EN - adds o_stall_cycles (saturating)
// Revision: 1.0 - initial release
// ============================================================================
module output_line_writer
  import bonsai_writer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int P          = 4,
  parameter int LINE_WIDTH = 512,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_base_addr,
  input  logic [31:0]             i_num_lines,
  input  logic [P*DATA_WIDTH-1:0] i_data,
  input  logic                    i_fifo_empty,
  output logic                    o_fifo_read,
  input  logic                    i_flush,
  output logic                    o_wr_valid,
  output logic [ADDR_WIDTH-1:0]   o_wr_addr,
  output logic [LINE_WIDTH-1:0]   o_wr_data,
  input  logic                    i_wr_ready,
  output logic                    o_busy,
  output logic                    o_done
`ifdef WRITER_PERF_EN
  ,
  output logic [31:0]             o_stall_cycles
`endif
);

  localparam int BEAT_W = P * DATA_WIDTH;
  localparam int R      = LINE_WIDTH / BEAT_W;
  localparam int SLOT_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [SLOT_W-1:0]     LAST_SLOT = SLOT_W'(R - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(line_bytes(LINE_WIDTH));

  if (!line_geometry_ok(LINE_WIDTH, BEAT_W)) begin : g_bad_geometry
    $error("output_line_writer: LINE_WIDTH must be a power-of-two multiple of P*DATA_WIDTH");
  end

  writer_state_e           state;
  logic [31:0]             num_lines;
  logic [31:0]             lines_loaded;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [SLOT_W-1:0]       slot;
  logic [LINE_WIDTH-1:0]   merged_line;
  logic [LINE_WIDTH-1:0]   padded_line;

  logic start_ok;
  logic out_free;
  logic accept;
  logic lines_left;
  logic run_load;
  logic pad_load;
  logic load;

  assign start_ok   = (state == ST_IDLE) && i_start;
  assign accept     = o_wr_valid && i_wr_ready;
  // Output register can take a new line this cycle: empty or draining.
  assign out_free   = !o_wr_valid || i_wr_ready;
  assign lines_left = (lines_loaded != num_lines);

  // Only the beat completing a line needs room in the output register;
  // earlier beats only go to the accumulator. Once every line of the job
  // has been loaded the FIFO is left alone.
  assign o_fifo_read = (state == ST_RUN) && !i_fifo_empty && lines_left &&
                       ((slot != LAST_SLOT) || out_free);

  assign run_load = o_fifo_read && (slot == LAST_SLOT);
  assign pad_load = (state == ST_FLUSH) && (slot != '0) && out_free && lines_left;
  assign load     = run_load || pad_load;

  line_packer #(
    .BEAT_W (BEAT_W),
    .R      (R),
    .SLOT_W (SLOT_W)
  ) u_packer (
    .clk         (i_clk),
    .rst         (i_rst),
    .clear       (start_ok || pad_load),
    .push        (o_fifo_read),
    .beat        (i_data),
    .slot        (slot),
    .merged_line (merged_line),
    .padded_line (padded_line)
  );

  // Job FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) state <= (i_num_lines == 32'd0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (!lines_left && accept) state <= ST_DONE;
          else if (i_flush)          state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // Slot 0 means any padded line is already in the output register;
          // finish as soon as that register drains.
          if ((slot == '0) && out_free) state <= ST_DONE;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Job counters and next line address
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      num_lines    <= '0;
      lines_loaded <= '0;
      next_addr    <= '0;
    end else if (start_ok) begin
      num_lines    <= i_num_lines;
      lines_loaded <= '0;
      next_addr    <= i_base_addr;
    end else if (load) begin
      lines_loaded <= lines_loaded + 32'd1;
      next_addr    <= next_addr + LINE_STEP;
    end
  end

  // Output register: a load and an accept in the same cycle hand over
  // back to back, so valid stays high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wr_valid <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
    end else if (load) begin
      o_wr_valid <= 1'b1;
      o_wr_addr  <= next_addr;
      o_wr_data  <= pad_load ? padded_line : merged_line;
    end else if (accept) begin
      o_wr_valid <= 1'b0;
    end
  end

  assign o_busy = (state == ST_RUN) || (state == ST_FLUSH);
  assign o_done = (state == ST_DONE);

`ifdef WRITER_PERF_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stall_cycles <= '0;
    end else if (start_ok) begin
      o_stall_cycles <= '0;
    end else if (o_wr_valid && !i_wr_ready && (o_stall_cycles != '1)) begin
      o_stall_cycles <= o_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_output_line_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_output_line_writer
// Purpose : Directed self-checking bench for output_line_writer at default
//           parameters: full job, beat ordering, backpressure, flush with
//           padding, address wrap, zero-line job and mid-job reset.
// Config  : WRITER_PERF_EN - also checks o_stall_cycles
// Revision: 1.0 - initial release
// ============================================================================
module tb_output_line_writer;

  localparam int DW = 32;
  localparam int PP = 4;
  localparam int LW = 512;
  localparam int AW = 64;
  localparam int BW = PP * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [AW-1:0] i_base_addr;
  logic [31:0]   i_num_lines;
  logic [BW-1:0] i_data;
  logic          i_fifo_empty;
  logic          o_fifo_read;
  logic          i_flush;
  logic          o_wr_valid;
  logic [AW-1:0] o_wr_addr;
  logic [LW-1:0] o_wr_data;
  logic          i_wr_ready;
  logic          o_busy;
  logic          o_done;
`ifdef WRITER_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  always #5 clk = ~clk;

  output_line_writer #(
    .DATA_WIDTH (DW),
    .P          (PP),
    .LINE_WIDTH (LW),
    .ADDR_WIDTH (AW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_num_lines  (i_num_lines),
    .i_data       (i_data),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_read  (o_fifo_read),
    .i_flush      (i_flush),
    .o_wr_valid   (o_wr_valid),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .i_wr_ready   (i_wr_ready),
    .o_busy       (o_busy),
    .o_done       (o_done)
`ifdef WRITER_PERF_EN
    ,
    .o_stall_cycles (stall_cycles)
`endif
  );

  // FWFT FIFO model
  logic [BW-1:0] fifo_mem [0:63];
  int            wr_cnt = 0;
  int            rd_ptr = 0;
  logic          fifo_clear;

  assign i_data       = fifo_mem[rd_ptr[5:0]];
  assign i_fifo_empty = (rd_ptr >= wr_cnt);

  always @(posedge clk) begin
    if (fifo_clear)       rd_ptr <= 0;
    else if (o_fifo_read) rd_ptr <= rd_ptr + 1;
  end

  // Write capture
  logic [AW-1:0] cap_addr [0:15];
  logic [LW-1:0] cap_data [0:15];
  int            n_wr = 0;
  int            cycle = 0;
  int            last_wr_cycle = 0;
  logic          cap_clear;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (cap_clear) begin
      n_wr <= 0;
    end else if (o_wr_valid && i_wr_ready) begin
      cap_addr[n_wr[3:0]] <= o_wr_addr;
      cap_data[n_wr[3:0]] <= o_wr_data;
      n_wr                <= n_wr + 1;
      last_wr_cycle       <= cycle;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Beat j carries records 4j+1 .. 4j+4, lowest record in the LSBs.
  function automatic logic [BW-1:0] beat_val(input int j);
    return {32'(4*j + 4), 32'(4*j + 3), 32'(4*j + 2), 32'(4*j + 1)};
  endfunction

  // Line n holds beats 4n..4n+3, first beat in the LSBs.
  function automatic logic [LW-1:0] exp_line(input int n);
    return {beat_val(4*n + 3), beat_val(4*n + 2), beat_val(4*n + 1), beat_val(4*n)};
  endfunction

  task automatic load_fifo(input int n);
    @(negedge clk);
    wr_cnt     = 0;
    fifo_clear = 1'b1;
    cap_clear  = 1'b1;
    @(negedge clk);
    fifo_clear = 1'b0;
    cap_clear  = 1'b0;
    for (int j = 0; j < n; j++) fifo_mem[j] = beat_val(j);
    wr_cnt = n;
  endtask

  task automatic start_job(input logic [AW-1:0] base, input logic [31:0] n);
    @(negedge clk);
    i_base_addr = base;
    i_num_lines = n;
    i_start     = 1'b1;
    @(negedge clk);
    i_start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    check(tag, LW'(seen), LW'(1));
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (o_wr_valid) seen = 1'b1;
    end
    check(tag, LW'(seen), LW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] hold_addr;
    logic [LW-1:0] hold_data;
    bit            ok;
    int            budget;

    rst         = 1'b1;
    i_start     = 1'b0;
    i_base_addr = '0;
    i_num_lines = '0;
    i_flush     = 1'b0;
    i_wr_ready  = 1'b1;
    fifo_clear  = 1'b1;
    cap_clear   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", LW'(o_wr_valid), LW'(0));
    check("rst_read",  LW'(o_fifo_read), LW'(0));
    check("rst_busy",  LW'(o_busy), LW'(0));
    check("rst_done",  LW'(o_done), LW'(0));
    check("rst_addr",  LW'(o_wr_addr), LW'(0));
    check("rst_data",  o_wr_data, LW'(0));
    rst        = 1'b0;
    fifo_clear = 1'b0;
    cap_clear  = 1'b0;

    // Full 8-line job, FIFO never empty, no backpressure
    load_fifo(40);
    start_job(64'h1000, 32'd8);
    check("t1_busy", LW'(o_busy), LW'(1));
    wait_done("t1_done", 100);
    check("t1_done_lat", LW'(cycle - last_wr_cycle), LW'(1));
    check("t1_busy_end", LW'(o_busy), LW'(0));
    check("t1_nwr", LW'(n_wr), LW'(8));
    check("t1_pops", LW'(rd_ptr), LW'(32));
    for (int n = 0; n < 8; n++) begin
      check($sformatf("t1_addr%0d", n), LW'(cap_addr[n]), LW'(64'h1000 + 64'(n * 64)));
      check($sformatf("t1_data%0d", n), cap_data[n], exp_line(n));
    end
    @(negedge clk);
    check("t1_done_pulse", LW'(o_done), LW'(0));

    // Backpressure: ready low for 10 cycles with a line pending
    load_fifo(40);
    start_job(64'h4000, 32'd8);
    wait_valid("t2_valid", 20);
    check("t2_pops_pre", LW'(rd_ptr), LW'(4));
    i_wr_ready = 1'b0;
    hold_addr  = o_wr_addr;
    hold_data  = o_wr_data;
    ok         = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!o_wr_valid || (o_wr_addr !== hold_addr) || (o_wr_data !== hold_data)) ok = 1'b0;
    end
    check("t2_stable", LW'(ok), LW'(1));
    check("t2_pops_stall", LW'(rd_ptr), LW'(7));
`ifdef WRITER_PERF_EN
    check("t2_stall_cnt", LW'(stall_cycles), LW'(10));
`endif
    i_wr_ready = 1'b1;
    wait_done("t2_done", 100);
    check("t2_nwr", LW'(n_wr), LW'(8));
    check("t2_pops", LW'(rd_ptr), LW'(32));
    ok = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (cap_data[n] !== exp_line(n)) ok = 1'b0;
      if (cap_addr[n] !== 64'h4000 + 64'(n * 64)) ok = 1'b0;
    end
    check("t2_lines", LW'(ok), LW'(1));

    // Flush after 6 beats: second line padded in slots 2 and 3
    load_fifo(6);
    start_job(64'h8000, 32'd8);
    budget = 0;
    while (rd_ptr < 6 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("t3_pops", LW'(rd_ptr), LW'(6));
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    wait_done("t3_done", 50);
    check("t3_nwr", LW'(n_wr), LW'(2));
    check("t3_data0", cap_data[0], exp_line(0));
    check("t3_addr1", LW'(cap_addr[1]), LW'(64'h8040));
    check("t3_data1", cap_data[1], {{(2*BW){1'b1}}, beat_val(5), beat_val(4)});

    // Address wrap across the top of the address space
    load_fifo(8);
    start_job(64'hFFFF_FFFF_FFFF_FFC0, 32'd2);
    wait_done("t4_done", 50);
    check("t4_nwr", LW'(n_wr), LW'(2));
    check("t4_addr0", LW'(cap_addr[0]), LW'(64'hFFFF_FFFF_FFFF_FFC0));
    check("t4_addr1", LW'(cap_addr[1]), LW'(64'h0));

    // Zero-line job goes straight to DONE without touching the FIFO
    load_fifo(4);
    start_job(64'h3000, 32'd0);
    check("t5_done", LW'(o_done), LW'(1));
    check("t5_busy", LW'(o_busy), LW'(0));
    @(negedge clk);
    check("t5_done_pulse", LW'(o_done), LW'(0));
    check("t5_pops", LW'(rd_ptr), LW'(0));
    check("t5_nwr", LW'(n_wr), LW'(0));

    // Reset while a line is pending, then a clean 1-line job
    load_fifo(16);
    i_wr_ready = 1'b0;
    start_job(64'h5000, 32'd4);
    wait_valid("t6_valid", 20);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", LW'(o_wr_valid), LW'(0));
    check("t6_rst_busy", LW'(o_busy), LW'(0));
    @(negedge clk);
    rst = 1'b0;
    load_fifo(8);
    i_wr_ready = 1'b1;
    start_job(64'h2000, 32'd1);
    wait_done("t6_done", 50);
    check("t6_nwr", LW'(n_wr), LW'(1));
    check("t6_addr", LW'(cap_addr[0]), LW'(64'h2000));
    check("t6_data", cap_data[0], exp_line(0));
    check("t6_pops", LW'(rd_ptr), LW'(4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
